if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the program counter, issues one instruction-memory

---
 rtl/if_fetch_stage.sv | 117 +++++++++++
 tb/tb_if_fetch_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage. It owns the program counter and issues one
//   instruction-memory read per PC over a req/ready handshake. It presents
//   {PC+step, Instruction} to the IF/ID register. It absorbs variable memory
//   latency, freeze stalls and branch redirects, including redirects that land
//   while a read is still outstanding.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   freeze            ID hazard stall: hold the presented instruction, keep the PC
//   branch_taken      one-cycle redirect pulse from EXE, target on branch_addr
//   imem_req/addr     read request to instruction memory (addr = pc)
//   imem_rdata/ready  read data, valid in the cycle imem_ready is high
//   PC                pc + PC_STEP of the presented instruction
//   Instruction       fetched instruction, 0 (NOP) when fetch_valid is low
//   fetch_valid       PC/Instruction carry a real instruction this cycle

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        fetch_valid
);

  localparam int unsigned XLEN = 32;

  localparam logic S_FETCH = 1'b0;
  localparam logic S_HOLD  = 1'b1;

  logic            state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] pc_next;

  assign pc_next = pc_q + XLEN'(PC_STEP);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_buf_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      discard_q  <= discard_d;
    end
  end

  // Next-state logic, branches take priority over every other event
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    discard_d  = discard_q;

    if (branch_taken) begin
      pc_d    = branch_addr;
      state_d = S_FETCH;
      // A read still outstanding returns later for the old pc; drop that one return.
      discard_d = (state_q == S_FETCH) && !imem_ready;
    end else if (state_q == S_FETCH) begin
      if (imem_ready) begin
        if (discard_q) begin
          // Stale return consumed; pc already holds the redirect target.
          discard_d = 1'b0;
        end else if (!freeze) begin
          pc_d = pc_next;
        end else begin
          inst_buf_d = imem_rdata;
          state_d    = S_HOLD;
        end
      end
    end else begin
      if (!freeze) begin
        pc_d    = pc_next;
        state_d = S_FETCH;
      end
    end
  end

  // Combinational outputs; reset masks the request and the valid flag
  always_comb begin
    imem_req    = rst && (state_q == S_FETCH);
    imem_addr   = pc_q;
    PC          = pc_next;
    fetch_valid = 1'b0;
    Instruction = '0;

    if (rst) begin
      if (state_q == S_FETCH) begin
        fetch_valid = imem_ready && !discard_q && !branch_taken;
      end else begin
        fetch_valid = !branch_taken;
      end
    end

    if (fetch_valid) begin
      Instruction = (state_q == S_FETCH) ? imem_rdata : inst_buf_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. The memory model answers with
//   addr ^ KEY when ready. Expected {PC, Instruction} pairs are queued as each
//   step is driven and are popped whenever the stage asserts fetch_valid.

module tb_if_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        fetch_valid;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .PC           (PC),
    .Instruction  (Instruction),
    .fetch_valid  (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_ready ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    sb.push_back(e);
  endtask

  // Pop and compare one expected instruction whenever the stage presents one
  task automatic sb_mon();
    exp_t e;
    if (fetch_valid === 1'b1) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=PC %h inst %h expected=none", PC, Instruction);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pc", PC, e.pc);
        chk("sb_inst", Instruction, e.inst);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    sb_mon();
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b1;

    // Reset state, with ready high to show the valid flag stays masked
    repeat (2) @(posedge clk);
    #1;
    at_neg();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_inst", Instruction, 32'd0);
    chk("rst_pc", PC, 32'd4);
    chk("rst_addr", imem_addr, 32'd0);
    next_cyc();
    rst = 1'b1;

    // Zero-wait streaming: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      push(32'(4 * i + 4), 32'(4 * i) ^ KEY);
      at_neg();
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_valid", 32'(fetch_valid), 32'd1);
      next_cyc();
    end

    // Restart from reset, then a 3-cycle memory wait
    rst = 1'b0;
    next_cyc();
    rst        = 1'b1;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr, 32'd0);
      chk("t2_valid", 32'(fetch_valid), 32'd0);
      next_cyc();
    end
    imem_ready = 1'b1;
    push(32'd4, 32'd0 ^ KEY);
    at_neg();
    chk("t2_addr4", imem_addr, 32'd0);
    chk("t2_valid4", 32'(fetch_valid), 32'd1);
    next_cyc();
    push(32'd8, 32'd4 ^ KEY);
    at_neg();
    next_cyc();

    // Freeze on the return at pc=8: held for three cycles, request off in HOLD
    freeze = 1'b1;
    push(32'd12, 32'd8 ^ KEY);
    at_neg();
    chk("t3_req_fetch", 32'(imem_req), 32'd1);
    next_cyc();
    imem_ready = 1'b0;
    push(32'd12, 32'd8 ^ KEY);
    at_neg();
    chk("t3_hold_req", 32'(imem_req), 32'd0);
    next_cyc();
    freeze = 1'b0;
    push(32'd12, 32'd8 ^ KEY);
    at_neg();
    chk("t3_hold_req2", 32'(imem_req), 32'd0);
    next_cyc();
    at_neg();
    chk("t3_next_addr", imem_addr, 32'd12);
    chk("t3_next_req", 32'(imem_req), 32'd1);
    chk("t3_next_valid", 32'(fetch_valid), 32'd0);
    next_cyc();
    imem_ready = 1'b1;
    push(32'd16, 32'd12 ^ KEY);
    at_neg();
    next_cyc();

    // Redirect while the read at pc=16 is outstanding; its return is dropped
    imem_ready = 1'b0;
    at_neg();
    chk("t4_addr", imem_addr, 32'd16);
    next_cyc();
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    at_neg();
    chk("t4_br_valid", 32'(fetch_valid), 32'd0);
    next_cyc();
    branch_taken = 1'b0;
    at_neg();
    chk("t4_tgt_addr", imem_addr, 32'h100);
    chk("t4_wait_valid", 32'(fetch_valid), 32'd0);
    next_cyc();
    imem_ready = 1'b1;
    at_neg();
    chk("t4_drop_valid", 32'(fetch_valid), 32'd0);
    chk("t4_drop_inst", Instruction, 32'd0);
    next_cyc();
    push(32'h104, 32'h100 ^ KEY);
    at_neg();
    chk("t4_refetch_addr", imem_addr, 32'h100);
    next_cyc();

    // Branch with ready and freeze in the same cycle: no HOLD
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    at_neg();
    chk("t5_valid", 32'(fetch_valid), 32'd0);
    chk("t5_inst", Instruction, 32'd0);
    next_cyc();
    branch_taken = 1'b0;
    freeze       = 1'b0;
    imem_ready   = 1'b0;
    at_neg();
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h40);
    next_cyc();
    imem_ready = 1'b1;
    push(32'h44, 32'h40 ^ KEY);
    at_neg();
    next_cyc();

    // Back-to-back redirects over one outstanding read: latest target wins
    imem_ready   = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    at_neg();
    next_cyc();
    branch_addr = 32'h300;
    at_neg();
    chk("bb_br_valid", 32'(fetch_valid), 32'd0);
    next_cyc();
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    at_neg();
    chk("bb_drop_valid", 32'(fetch_valid), 32'd0);
    next_cyc();
    push(32'h304, 32'h300 ^ KEY);
    at_neg();
    chk("bb_addr", imem_addr, 32'h300);
    next_cyc();

    // PC wrap at the top of the address space
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    at_neg();
    chk("wrap_br_valid", 32'(fetch_valid), 32'd0);
    next_cyc();
    branch_taken = 1'b0;
    push(32'd0, 32'hFFFF_FFFC ^ KEY);
    at_neg();
    chk("wrap_pc", PC, 32'd0);
    next_cyc();
    push(32'd4, 32'd0 ^ KEY);
    at_neg();
    chk("wrap_addr", imem_addr, 32'd0);
    next_cyc();

    // Reset asserted mid-read clears outputs immediately
    imem_ready = 1'b0;
    at_neg();
    chk("t6_req_pre", 32'(imem_req), 32'd1);
    chk("t6_addr_pre", imem_addr, 32'd4);
    next_cyc();
    #1;
    rst        = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_valid", 32'(fetch_valid), 32'd0);
    chk("t6_inst", Instruction, 32'd0);
    chk("t6_pc", PC, 32'd4);
    chk("t6_addr", imem_addr, 32'd0);
    next_cyc();
    rst = 1'b1;
    push(32'd4, 32'd0 ^ KEY);
    at_neg();
    chk("t6_restart_addr", imem_addr, 32'd0);
    chk("t6_restart_valid", 32'(fetch_valid), 32'd1);
    next_cyc();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
